// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave with TX/RX FIFOs. All logic runs in the clk100 domain.
// The SPI pins are treated as asynchronous inputs. They pass through 2-FF
// synchronisers, and edges are found on the synchronised copies.
//
// Ports
//   clk100, rst          system clock, async active-high reset
//   mode_i               {CPOL, CPHA}, latched at frame start
//   sclk_i/csn_i/mosi_i  SPI pins from the master (asynchronous)
//   miso_o, miso_oe_o    slave data out and its output enable (frame active)
//   tx_*                 TX FIFO write side: data, write strobe, full, level
//   rx_*                 RX FIFO read side: show-ahead head, valid, pop, level
//   rx_overflow_o        sticky: an RX word was dropped
//   tx_underrun_o        sticky: IDLE_WORD was loaded
//   clear_i              flush both FIFOs and clear both sticky flags
//
// state    | meaning
// S_IDLE   | no frame; MISO released, waiting for a synced CS fall
// S_ACTIVE | frame in progress; sample/shift on SCLK edges per latched mode
module spi_slave_fifo #(
  parameter int DATA_W = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic                            clk100,
  input  logic                            rst,
  input  logic [1:0]                      mode_i,
  input  logic                            sclk_i,
  input  logic                            csn_i,
  input  logic                            mosi_i,
  output logic                            miso_o,
  output logic                            miso_oe_o,
  input  logic [DATA_W-1:0]               tx_data_i,
  input  logic                            tx_wr_i,
  output logic                            tx_full_o,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level_o,
  output logic [DATA_W-1:0]               rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_rd_i,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level_o,
  output logic                            rx_overflow_o,
  output logic                            tx_underrun_o,
  input  logic                            clear_i
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXL = $clog2(TX_DEPTH + 1);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXL = $clog2(RX_DEPTH + 1);
  localparam int CW  = $clog2(DATA_W + 1);
  localparam logic [TXL-1:0] TX_FULL_CNT = TXL'(TX_DEPTH);
  localparam logic [RXL-1:0] RX_FULL_CNT = RXL'(RX_DEPTH);
  localparam logic [CW-1:0]  LAST_BIT    = CW'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state, state_nxt;

  // The CS synchroniser resets to 0 (asserted). If CS is still low when reset
  // is released, no fall is seen, so a frame cut by reset is not resumed.
  logic [1:0] sclk_sync, csn_sync, mosi_sync;
  logic       sclk_d, csn_d;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      csn_sync  <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_i};
      csn_sync  <= {csn_sync[0], csn_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      sclk_d    <= sclk_sync[1];
      csn_d     <= csn_sync[1];
    end
  end

  logic [1:0]        mode_q;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_nxt, load_word;
  logic sclk_rise, sclk_fall, csn_fall, csn_rise, lead, trail;
  logic active, sample_ev, shift_ev, word_done, load, start;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign csn_fall  = ~csn_sync[1] & csn_d;
  assign csn_rise  = csn_sync[1] & ~csn_d;
  assign lead      = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail     = mode_q[1] ? sclk_rise : sclk_fall;
  assign active    = (state == S_ACTIVE);
  assign start     = (state == S_IDLE) && csn_fall;

  assign sample_ev = active && !csn_rise && (mode_q[0] ? trail : lead);
  // With bit_cnt at 0 the first bit of the current word is already on MISO,
  // so the shift edge must not advance the register.
  assign shift_ev  = active && !csn_rise && (mode_q[0] ? lead : trail) && (bit_cnt != '0);
  assign word_done = sample_ev && (bit_cnt == LAST_BIT);
  assign load      = start || word_done;
  assign rx_nxt    = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_sync[1]}
                               : {mosi_sync[1], rx_sr[DATA_W-1:1]};

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    miso_oe_o = 1'b0;
    miso_o    = 1'b0;
    case (state)
      S_IDLE:   if (csn_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        miso_oe_o = 1'b1;
        miso_o    = MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0];
        if (csn_rise) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
    end else begin
      if (load)          tx_sr <= load_word;
      else if (shift_ev) tx_sr <= MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
      if (start) begin
        mode_q  <= mode_i;
        bit_cnt <= '0;
      end else if (sample_ev) begin
        rx_sr   <= rx_nxt;
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TXA-1:0]    tx_wp, tx_rp;
  logic [TXL-1:0]    tx_cnt;
  logic              tx_wr_ok, tx_pop;

  assign tx_full_o  = (tx_cnt == TX_FULL_CNT);
  assign tx_level_o = tx_cnt;
  assign tx_wr_ok   = tx_wr_i && !tx_full_o;
  assign tx_pop     = load && (tx_cnt != '0);
  assign load_word  = (tx_cnt != '0) ? tx_mem[tx_rp] : IDLE_WORD;

  always_ff @(posedge clk100) begin
    if (tx_wr_ok && !clear_i) tx_mem[tx_wp] <= tx_data_i;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0; tx_underrun_o <= 1'b0;
    end else if (clear_i) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0; tx_underrun_o <= 1'b0;
    end else begin
      if (tx_wr_ok) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)   tx_rp <= tx_rp + 1'b1;
      case ({tx_wr_ok, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (load && (tx_cnt == '0)) tx_underrun_o <= 1'b1;
    end
  end

  // RX FIFO; a full FIFO still accepts a push when a pop happens the same cycle
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RXA-1:0]    rx_wp, rx_rp;
  logic [RXL-1:0]    rx_cnt;
  logic              rx_pop, rx_acc, rx_full;

  assign rx_full    = (rx_cnt == RX_FULL_CNT);
  assign rx_valid_o = (rx_cnt != '0);
  assign rx_level_o = rx_cnt;
  assign rx_pop     = rx_rd_i && rx_valid_o;
  assign rx_acc     = word_done && (!rx_full || rx_pop);
  assign rx_data_o  = rx_valid_o ? rx_mem[rx_rp] : '0;

  always_ff @(posedge clk100) begin
    if (rx_acc && !clear_i) rx_mem[rx_wp] <= rx_nxt;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0; rx_overflow_o <= 1'b0;
    end else if (clear_i) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0; rx_overflow_o <= 1'b0;
    end else begin
      if (rx_acc) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      case ({rx_acc, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (word_done && !rx_acc) rx_overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_fifo.sv
module tb_spi_slave_fifo;
  localparam logic [7:0] IDLE_W = 8'hEE;
  localparam int RXD = 4;
  localparam int TXD = 16;

  logic       clk100 = 1'b0;
  logic       rst;
  logic [1:0] mode_i;
  logic       sclk_i, csn_i, mosi_i;
  logic       miso_o, miso_oe_o;
  logic [7:0] tx_data_i;
  logic       tx_wr_i;
  logic       tx_full_o;
  logic [4:0] tx_level_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_rd_i;
  logic [2:0] rx_level_o;
  logic       rx_overflow_o, tx_underrun_o;
  logic       clear_i;

  spi_slave_fifo #(.DATA_W(8), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .MSB_FIRST(1'b1),
                   .IDLE_WORD(IDLE_W)) dut (
    .clk100(clk100), .rst(rst), .mode_i(mode_i), .sclk_i(sclk_i), .csn_i(csn_i),
    .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data_i(tx_data_i),
    .tx_wr_i(tx_wr_i), .tx_full_o(tx_full_o), .tx_level_o(tx_level_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_rd_i(rx_rd_i),
    .rx_level_o(rx_level_o), .rx_overflow_o(rx_overflow_o),
    .tx_underrun_o(tx_underrun_o), .clear_i(clear_i));

  always #5 clk100 = ~clk100;

  int checks = 0;
  int failures = 0;

  // reference model: plain queues and sticky bits
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       ovf_m, unr_m;
  logic [7:0] mosi_w[9];
  logic [7:0] miso_w[9];
  logic [7:0] exp_miso[9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk100);
    tx_data_i = d;
    tx_wr_i = 1'b1;
    @(negedge clk100);
    tx_wr_i = 1'b0;
    if (tx_q.size() < TXD) tx_q.push_back(d);
  endtask

  task automatic do_clear();
    @(negedge clk100);
    clear_i = 1'b1;
    @(negedge clk100);
    clear_i = 1'b0;
    tx_q.delete();
    rx_q.delete();
    ovf_m = 1'b0;
    unr_m = 1'b0;
  endtask

  // Master model: half SCLK period is 60 ns (6 clk100 cycles).
  task automatic spi_frame(input logic [1:0] mode, input int nbits);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    @(negedge clk100);
    mode_i = mode;
    sclk_i = cpol;
    #100;
    mosi_i = mosi_w[0][7];
    csn_i = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        miso_w[i/8][7-(i%8)] = miso_o;
        sclk_i = ~cpol;
        #60;
        sclk_i = cpol;
        if (i + 1 < nbits) mosi_i = mosi_w[(i+1)/8][7-((i+1)%8)];
        #60;
      end else begin
        sclk_i = ~cpol;
        mosi_i = mosi_w[i/8][7-(i%8)];
        #60;
        miso_w[i/8][7-(i%8)] = miso_o;
        sclk_i = cpol;
        #60;
      end
    end
    #40;
    csn_i = 1'b1;
    #100;
  endtask

  // Frame effect from the rules: one load at CS fall plus one per completed
  // word; each completed word is pushed to RX (dropped when RX holds RXD).
  task automatic model_frame(input int nbits);
    int nw;
    nw = nbits / 8;
    for (int i = 0; i <= nw; i++) begin
      if (tx_q.size() > 0) exp_miso[i] = tx_q.pop_front();
      else begin
        exp_miso[i] = IDLE_W;
        unr_m = 1'b1;
      end
    end
    for (int i = 0; i < nw; i++) begin
      if (rx_q.size() < RXD) rx_q.push_back(mosi_w[i]);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] mode, input int nbits);
    int nw, k;
    spi_frame(mode, nbits);
    model_frame(nbits);
    nw = nbits / 8;
    k = nbits % 8;
    @(negedge clk100);
    for (int i = 0; i < nw; i++)
      chk($sformatf("%s_miso%0d", tag, i), miso_w[i], exp_miso[i]);
    if (k != 0)
      chk($sformatf("%s_miso_part", tag), miso_w[nw] >> (8 - k), exp_miso[nw] >> (8 - k));
    chk({tag, "_rx_level"}, rx_level_o, rx_q.size());
    chk({tag, "_tx_level"}, tx_level_o, tx_q.size());
    chk({tag, "_ovf"}, rx_overflow_o, ovf_m);
    chk({tag, "_unr"}, tx_underrun_o, unr_m);
    chk({tag, "_oe_idle"}, miso_oe_o, 1'b0);
  endtask

  task automatic drain_rx(input string tag);
    int n;
    n = rx_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk100);
      chk({tag, "_rx_valid"}, rx_valid_o, 1'b1);
      chk($sformatf("%s_rx%0d", tag, i), rx_data_o, rx_q[0]);
      rx_rd_i = 1'b1;
      @(negedge clk100);
      rx_rd_i = 1'b0;
      void'(rx_q.pop_front());
    end
    @(negedge clk100);
    chk({tag, "_rx_empty"}, rx_valid_o, 1'b0);
  endtask

  initial begin
    logic [1:0] m;
    int nw;
    rst = 1'b1;
    mode_i = 2'b00;
    sclk_i = 1'b0;
    csn_i = 1'b1;
    mosi_i = 1'b0;
    tx_data_i = '0;
    tx_wr_i = 1'b0;
    rx_rd_i = 1'b0;
    clear_i = 1'b0;
    ovf_m = 1'b0;
    unr_m = 1'b0;
    #32;
    chk("rst_miso", miso_o, 1'b0);
    chk("rst_oe", miso_oe_o, 1'b0);
    chk("rst_full", tx_full_o, 1'b0);
    chk("rst_txlvl", tx_level_o, 0);
    chk("rst_rxdata", rx_data_o, 0);
    chk("rst_rxvalid", rx_valid_o, 1'b0);
    chk("rst_rxlvl", rx_level_o, 0);
    chk("rst_ovf", rx_overflow_o, 1'b0);
    chk("rst_unr", tx_underrun_o, 1'b0);
    @(negedge clk100);
    rst = 1'b0;
    #100;

    // mode 0, two words; a third TX word covers the reload after word 2
    tx_write(8'hA5);
    tx_write(8'h3C);
    tx_write(8'($urandom));
    mosi_w[0] = 8'h5A;
    mosi_w[1] = 8'hC3;
    run_and_check("m0", 2'b00, 16);
    drain_rx("m0");

    // modes 1..3 with fixed edge-case master data
    for (int md = 1; md < 4; md++) begin
      for (int i = 0; i < 5; i++) tx_write(8'($urandom));
      mosi_w[0] = 8'h01; mosi_w[1] = 8'h80; mosi_w[2] = 8'hFF; mosi_w[3] = 8'h00;
      run_and_check($sformatf("md%0d", md), 2'(md), 32);
      drain_rx($sformatf("md%0d", md));
    end

    // empty TX: idle word and sticky underrun, cleared by clear_i
    mosi_w[0] = 8'($urandom);
    mosi_w[1] = 8'($urandom);
    run_and_check("unr", 2'b00, 16);
    drain_rx("unr");
    do_clear();
    @(negedge clk100);
    chk("unr_cleared", tx_underrun_o, 1'b0);

    // RX overflow: 5 words, no reads
    for (int i = 0; i < 6; i++) tx_write(8'($urandom));
    for (int i = 0; i < 5; i++) mosi_w[i] = 8'($urandom);
    run_and_check("ovf", 2'($urandom_range(0, 3)), 40);
    chk("ovf_head", rx_data_o, mosi_w[0]);
    drain_rx("ovf");
    do_clear();
    @(negedge clk100);
    chk("ovf_cleared", rx_overflow_o, 1'b0);

    // read of an empty RX FIFO is ignored
    @(negedge clk100);
    rx_rd_i = 1'b1;
    @(negedge clk100);
    rx_rd_i = 1'b0;
    chk("rd_empty_lvl", rx_level_o, 0);

    // CS rise after 5 bits, then a one-word frame uses the next TX word
    for (int i = 0; i < 3; i++) tx_write(8'($urandom));
    mosi_w[0] = 8'($urandom);
    run_and_check("part", 2'b00, 5);
    mosi_w[0] = 8'($urandom);
    run_and_check("after_part", 2'b00, 8);
    drain_rx("after_part");

    // TX full boundary: 17th write ignored
    for (int i = 0; i < 17; i++) tx_write(8'($urandom));
    @(negedge clk100);
    chk("txfull_flag", tx_full_o, tx_q.size() == TXD);
    chk("txfull_lvl", tx_level_o, tx_q.size());
    do_clear();
    @(negedge clk100);
    chk("clr_txlvl", tx_level_o, 0);
    chk("clr_full", tx_full_o, 1'b0);

    // randomized frames
    for (int it = 0; it < 5; it++) begin
      m = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 3);
      for (int i = 0; i < $urandom_range(0, 4); i++) tx_write(8'($urandom));
      for (int i = 0; i < nw; i++) mosi_w[i] = 8'($urandom);
      run_and_check($sformatf("rnd%0d", it), m, nw * 8);
      drain_rx($sformatf("rnd%0d", it));
    end

    // async reset mid-word
    tx_write(8'($urandom));
    tx_write(8'($urandom));
    @(negedge clk100);
    mode_i = 2'b00;
    sclk_i = 1'b0;
    mosi_i = 1'b1;
    csn_i = 1'b0;
    #80;
    for (int i = 0; i < 3; i++) begin
      sclk_i = 1'b1; #60;
      sclk_i = 1'b0; #60;
    end
    chk("mid_oe_before", miso_oe_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_oe", miso_oe_o, 1'b0);
    chk("mid_miso", miso_o, 1'b0);
    chk("mid_txlvl", tx_level_o, 0);
    chk("mid_rxlvl", rx_level_o, 0);
    chk("mid_rxvalid", rx_valid_o, 1'b0);
    chk("mid_unr", tx_underrun_o, 1'b0);
    tx_q.delete();
    rx_q.delete();
    ovf_m = 1'b0;
    unr_m = 1'b0;
    #29;
    rst = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) begin
      sclk_i = 1'b1; #60;
      sclk_i = 1'b0; #60;
    end
    @(negedge clk100);
    chk("no_resume_oe", miso_oe_o, 1'b0);
    chk("no_resume_rx", rx_level_o, 0);
    csn_i = 1'b1;
    #100;
    tx_write(8'($urandom));
    tx_write(8'($urandom));
    mosi_w[0] = 8'($urandom);
    run_and_check("post_rst", 2'($urandom_range(0, 3)), 8);
    drain_rx("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
